// File: rtl/mmm_serial_if.sv
// mmm_serial_if: operand/result bundle between the exponentiation controller
// (master) and the bit-serial Montgomery multiplier (slave).
//
// Handshake: the master raises start with op_a/op_b/modulus stable; the slave
// accepts it only on an enabled edge while idle, then holds busy high until
// the done cycle inclusive. done is a single enabled-cycle pulse marking
// result valid, and result is held until the next accept. start while busy
// is ignored, so there is no queueing and no abort.
interface mmm_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;

  modport master (
    output start, op_a, op_b, modulus,
    input  busy, done, result
  );

  modport slave (
    input  start, op_a, op_b, modulus,
    output busy, done, result
  );
endinterface

// File: rtl/mmm_serial.sv
// mmm_serial: bit-serial radix-2 Montgomery multiplier, R = A*B*2^-WIDTH mod M.
// One bit of A is consumed per enabled clock: WIDTH CALC cycles, one SUB
// cycle that writes result, one DONE cycle carrying the done pulse.
//
// Build option: define MMM_FINAL_SUB_EN to apply the conditional final
// subtraction (result in [0, M)). Without it result is the unreduced
// accumulator in [0, 2M), which is fine for chained Montgomery operations.
//
// state_dbg exposes the FSM state (0 IDLE, 1 CALC, 2 SUB, 3 DONE).
module mmm_serial #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         ena,
  mmm_serial_if.slave  bus,
  output logic [1:0]   state_dbg
);

  // Accumulator needs two guard bits: t + q*M < 4M < 2^(WIDTH+2).
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   result_q;

  logic [AW-1:0]    t_sum;
  logic [AW-1:0]    u_sum;
  logic [WIDTH:0]   fin;

  // One Montgomery iteration: add B if the current A bit is set, then add M
  // if the partial sum is odd so the following right shift is exact.
  always_comb begin
    t_sum = acc + (a_sh[0] ? {2'b00, b_q} : '0);
    u_sum = t_sum + (t_sum[0] ? {2'b00, m_q} : '0);
  end

  // Final value written in SUB; acc < 2M so WIDTH+1 bits always suffice.
  always_comb begin
`ifdef MMM_FINAL_SUB_EN
    if (acc >= {2'b00, m_q}) begin
      fin = (WIDTH+1)'(acc - {2'b00, m_q});
    end else begin
      fin = acc[WIDTH:0];
    end
`else
    fin = acc[WIDTH:0];
`endif
  end

  // Control FSM and datapath registers; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.op_a;
            b_q    <= bus.op_b;
            m_q    <= bus.modulus;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc  <= u_sum >> 1;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_SUB;
          end
        end
        S_SUB: begin
          result_q <= fin;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mmm_serial.sv
// tb_mmm_serial: directed vector table plus hand-written sequences for
// stall, back-to-back issue, ignored start and mid-operation reset.
`timescale 1ns/1ps
module tb_mmm_serial;
  localparam int W = 8;

`ifdef MMM_FINAL_SUB_EN
  localparam logic [W:0] EXP_M255 = 9'd1;
`else
  localparam logic [W:0] EXP_M255 = 9'd256;
`endif

  // ---------------- clock / reset ----------------
  logic       clk  = 1'b0;
  logic       rstb = 1'b0;
  logic       ena  = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mmm_serial_if #(.WIDTH(W)) bus ();

  mmm_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_at  = 0;
  int stall_len = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present operands with start high and let the next enabled edge accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] m, input logic [W:0] exp,
                       input bit keep_start);
    @(negedge clk);
    bus.op_a    = a;
    bus.op_b    = b;
    bus.modulus = m;
    bus.start   = 1'b1;
    ena         = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    @(negedge clk);
    if (!keep_start) bus.start = 1'b0;
  endtask

  // Called at the first negedge after accept (cycle 1); returns at the done cycle.
  task automatic wait_done(output int lat, output int bcnt, output bit stable);
    logic [W:0] r0;
    int n;
    r0 = bus.result;
    lat = 0;
    bcnt = 0;
    stable = 1'b1;
    n = 1;
    while (n < 200) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.result !== r0) stable = 1'b0;
      ena = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
      @(negedge clk);
      n++;
    end
    ena = 1'b1;
  endtask

  task automatic finish_op(input string nm, input int extra, input int hold);
    int lat;
    int bcnt;
    bit stable;
    wait_done(lat, bcnt, stable);
    check({nm, "_latency"}, 32'(lat), 32'(W + 2 + extra));
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'(W + 2 + extra));
    check({nm, "_result_stable"}, 32'(stable), 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", nm);
    end else begin
      check({nm, "_result"}, 32'(bus.result), 32'(exp_q.pop_front()));
    end
    if (hold > 0) begin
      ena = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check({nm, "_done_held"}, 32'(bus.done), 32'd1);
      end
      ena = 1'b1;
    end
    @(negedge clk);
    check({nm, "_done_low"}, 32'(bus.done), 32'd0);
    check({nm, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W:0]   exp;
    string        name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 8'd1,   b: 8'd1,   m: 8'd239, exp: 9'd225,   name: "one_one"};
    vecs[1] = '{a: 8'd254, b: 8'd254, m: 8'd255, exp: EXP_M255, name: "m255"};
    vecs[2] = '{a: 8'd0,   b: 8'd200, m: 8'd239, exp: 9'd0,     name: "a_zero"};
    vecs[3] = '{a: 8'd17,  b: 8'd17,  m: 8'd239, exp: 9'd17,    name: "mont_one"};
    vecs[4] = '{a: 8'd5,   b: 8'd7,   m: 8'd13,  exp: 9'd1,     name: "small_m"};
    vecs[5] = '{a: 8'd200, b: 8'd0,   m: 8'd239, exp: 9'd0,     name: "b_zero"};
    vecs[6] = '{a: 8'd238, b: 8'd1,   m: 8'd239, exp: 9'd14,    name: "neg_one"};

    bus.start   = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.modulus = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rstb = 1'b1;

    // start while ena is low must not be accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a = 8'd1; bus.op_b = 8'd1; bus.modulus = 8'd239;
    repeat (2) @(negedge clk);
    check("ena_low_busy", 32'(bus.busy), 32'd0);
    check("ena_low_state", 32'(state_dbg), 32'd0);
    bus.start = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, 1'b0);
      finish_op(vecs[i].name, 0, 0);
    end

    // ena low for 3 cycles mid-CALC, then held low while done is up
    stall_at  = 4;
    stall_len = 3;
    issue(8'd238, 8'd238, 8'd239, 9'd225, 1'b0);
    finish_op("stall", 3, 2);
    stall_len = 0;

    // start held through the op, operands changed mid-op, then back-to-back
    issue(8'd1, 8'd1, 8'd239, 9'd225, 1'b1);
    bus.op_a = 8'd17;
    bus.op_b = 8'd17;
    finish_op("b2b_first", 0, 0);
    check("b2b_idle_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    exp_q.push_back(9'd17);
    @(negedge clk);
    bus.start = 1'b0;
    finish_op("b2b_second", 0, 0);

    // Reset during CALC aborts at once; result was 17 before
    issue(8'd238, 8'd238, 8'd239, 9'd225, 1'b0);
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rstb = 1'b1;
    issue(8'd238, 8'd238, 8'd239, 9'd225, 1'b0);
    finish_op("after_rst", 0, 0);
    issue(8'd254, 8'd254, 8'd255, EXP_M255, 1'b0);
    finish_op("after_rst_m255", 0, 0);

    // ---------------- final report ----------------
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
